// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares the single frame-memory read port between the VGA
// scan-out and the edge detector. The display phase selects which side has
// priority. A starvation override guarantees the low-priority side a slot.
// Read responses are registered with one cycle of latency.
module frame_mem_arbiter #(
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blank,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              ed_req,
    input  logic [ADDR_W-1:0] ed_addr,
    output logic              ed_gnt,
    output logic [DATA_W-1:0] ed_rdata,
    output logic              ed_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // STARVE_LIMIT is at most 255, so an 8-bit counter always holds it
    localparam int unsigned STARVE_W = 8;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]    CNT_SAT    = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        VGA_PRIO = 1'b0,
        ED_PRIO  = 1'b1
    } mode_e;

    mode_e               state_q, state_d;

    logic                vga_gnt_c;
    logic                ed_gnt_c;
    logic                both_req_c;

    logic [STARVE_W-1:0] vga_starve_q, vga_starve_d;
    logic [STARVE_W-1:0] ed_starve_q,  ed_starve_d;

    logic [ADDR_W-1:0]   last_addr_q,  last_addr_d;
    logic [ADDR_W-1:0]   mem_addr_c;

    logic [DATA_W-1:0]   vga_rdata_q,  vga_rdata_d;
    logic [DATA_W-1:0]   ed_rdata_q,   ed_rdata_d;
    logic                vga_rvalid_q, vga_rvalid_d;
    logic                ed_rvalid_q,  ed_rvalid_d;

    logic [CNT_W-1:0]    conflict_q,   conflict_d;

    assign both_req_c = vga_req & ed_req;

    // ------------------------------------------------------------------
    // Priority-mode FSM
    // ------------------------------------------------------------------

    // Mode register; the mode lags blank by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= VGA_PRIO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode follows the display phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            VGA_PRIO: if (blank)  state_d = ED_PRIO;
            ED_PRIO:  if (!blank) state_d = VGA_PRIO;
            default:  state_d = VGA_PRIO;
        endcase
    end

    // Grant decode: at most one grant; a saturated low-priority counter overrides the mode
    always_comb begin
        vga_gnt_c = 1'b0;
        ed_gnt_c  = 1'b0;
        if (rst) begin
            if (vga_req && !ed_req) begin
                vga_gnt_c = 1'b1;
            end else if (ed_req && !vga_req) begin
                ed_gnt_c = 1'b1;
            end else if (both_req_c) begin
                case (state_q)
                    VGA_PRIO: begin
                        if (ed_starve_q == STARVE_MAX) ed_gnt_c  = 1'b1;
                        else                           vga_gnt_c = 1'b1;
                    end
                    ED_PRIO: begin
                        if (vga_starve_q == STARVE_MAX) vga_gnt_c = 1'b1;
                        else                            ed_gnt_c  = 1'b1;
                    end
                    default: vga_gnt_c = 1'b1;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory address path
    // ------------------------------------------------------------------

    // Drive the granted address; hold the last served address when idle
    always_comb begin
        mem_addr_c  = last_addr_q;
        last_addr_d = last_addr_q;
        if (vga_gnt_c) begin
            mem_addr_c  = vga_addr;
            last_addr_d = vga_addr;
        end else if (ed_gnt_c) begin
            mem_addr_c  = ed_addr;
            last_addr_d = ed_addr;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counters
    // ------------------------------------------------------------------

    // Count consecutive denied cycles; clear on grant or withdrawal, saturate at the limit
    always_comb begin
        vga_starve_d = vga_starve_q;
        ed_starve_d  = ed_starve_q;

        if (!vga_req || vga_gnt_c) begin
            vga_starve_d = '0;
        end else if (vga_starve_q != STARVE_MAX) begin
            vga_starve_d = vga_starve_q + STARVE_W'(1);
        end

        if (!ed_req || ed_gnt_c) begin
            ed_starve_d = '0;
        end else if (ed_starve_q != STARVE_MAX) begin
            ed_starve_d = ed_starve_q + STARVE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read responses and statistics
    // ------------------------------------------------------------------

    // Capture memory data for whichever side was granted this cycle
    always_comb begin
        vga_rdata_d  = vga_rdata_q;
        ed_rdata_d   = ed_rdata_q;
        vga_rvalid_d = vga_gnt_c;
        ed_rvalid_d  = ed_gnt_c;
        if (vga_gnt_c) vga_rdata_d = mem_rdata;
        if (ed_gnt_c)  ed_rdata_d  = mem_rdata;
    end

    // Saturating count of cycles where both sides request
    always_comb begin
        conflict_d = conflict_q;
        if (both_req_c && (conflict_q != CNT_SAT)) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // Datapath and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_starve_q <= '0;
            ed_starve_q  <= '0;
            last_addr_q  <= '0;
            vga_rdata_q  <= '0;
            ed_rdata_q   <= '0;
            vga_rvalid_q <= 1'b0;
            ed_rvalid_q  <= 1'b0;
            conflict_q   <= '0;
        end else begin
            vga_starve_q <= vga_starve_d;
            ed_starve_q  <= ed_starve_d;
            last_addr_q  <= last_addr_d;
            vga_rdata_q  <= vga_rdata_d;
            ed_rdata_q   <= ed_rdata_d;
            vga_rvalid_q <= vga_rvalid_d;
            ed_rvalid_q  <= ed_rvalid_d;
            conflict_q   <= conflict_d;
        end
    end

    assign vga_gnt      = vga_gnt_c;
    assign ed_gnt       = ed_gnt_c;
    assign mem_addr     = mem_addr_c;
    assign vga_rdata    = vga_rdata_q;
    assign vga_rvalid   = vga_rvalid_q;
    assign ed_rdata     = ed_rdata_q;
    assign ed_rvalid    = ed_rvalid_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed vectors for the frame-memory arbiter.
module tb_frame_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        blank;
    logic        vga_req;
    logic [6:0]  vga_addr;
    logic        vga_gnt;
    logic [63:0] vga_rdata;
    logic        vga_rvalid;
    logic        ed_req;
    logic [6:0]  ed_addr;
    logic        ed_gnt;
    logic [63:0] ed_rdata;
    logic        ed_rvalid;
    logic [6:0]  mem_addr;
    logic [63:0] mem_rdata;
    logic [15:0] conflict_cnt;

    frame_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .blank        (blank),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_gnt      (vga_gnt),
        .vga_rdata    (vga_rdata),
        .vga_rvalid   (vga_rvalid),
        .ed_req       (ed_req),
        .ed_addr      (ed_addr),
        .ed_gnt       (ed_gnt),
        .ed_rdata     (ed_rdata),
        .ed_rvalid    (ed_rvalid),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        blank;
        logic        vreq;
        logic [6:0]  vaddr;
        logic        ereq;
        logic [6:0]  eaddr;
        logic [63:0] mrd;
        logic        xvg;
        logic        xeg;
        logic [6:0]  xma;
        logic        xvrv;
        logic [63:0] xvrd;
        logic        xerv;
        logic [63:0] xerd;
        logic [15:0] xcnt;
    } vec_t;

    int          checks;
    int          errors;
    vec_t        tbl [9];

    // scoreboard state for the looped sequences
    logic [63:0] exp_vrd;
    logic [63:0] exp_erd;
    logic [15:0] exp_cnt;
    logic [6:0]  exp_maddr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive on negedge, check combinational outputs, then registered outputs after posedge
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        blank     = v.blank;
        vga_req   = v.vreq;
        vga_addr  = v.vaddr;
        ed_req    = v.ereq;
        ed_addr   = v.eaddr;
        mem_rdata = v.mrd;
        #1;
        chk($sformatf("%s vga_gnt", tag), 64'(vga_gnt), 64'(v.xvg));
        chk($sformatf("%s ed_gnt", tag), 64'(ed_gnt), 64'(v.xeg));
        chk($sformatf("%s mem_addr", tag), 64'(mem_addr), 64'(v.xma));
        @(posedge clk);
        #1;
        chk($sformatf("%s vga_rvalid", tag), 64'(vga_rvalid), 64'(v.xvrv));
        chk($sformatf("%s vga_rdata", tag), vga_rdata, v.xvrd);
        chk($sformatf("%s ed_rvalid", tag), 64'(ed_rvalid), 64'(v.xerv));
        chk($sformatf("%s ed_rdata", tag), ed_rdata, v.xerd);
        chk($sformatf("%s conflict_cnt", tag), 64'(conflict_cnt), 64'(v.xcnt));
    endtask

    // build a vector from the expected grant, tracking held data/address/count
    task automatic run(input logic b, input logic vr, input logic [6:0] va,
                       input logic er, input logic [6:0] ea, input logic [63:0] md,
                       input logic xv, input logic xe, input string tag);
        vec_t v;
        if (xv) exp_vrd = md;
        if (xe) exp_erd = md;
        if (vr && er && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (xv)      exp_maddr = va;
        else if (xe) exp_maddr = ea;
        v.blank = b;   v.vreq = vr;  v.vaddr = va;
        v.ereq  = er;  v.eaddr = ea; v.mrd = md;
        v.xvg   = xv;  v.xeg  = xe;  v.xma = exp_maddr;
        v.xvrv  = xv;  v.xvrd = exp_vrd;
        v.xerv  = xe;  v.xerd = exp_erd;
        v.xcnt  = exp_cnt;
        apply(v, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        //        blank vreq vaddr ereq eaddr mrd      vgnt egnt maddr vrv vrd      erv erd      cnt
        tbl[0] = '{1'b0, 1'b1, 7'd5, 1'b0, 7'd0,  64'hA5, 1'b1, 1'b0, 7'd5,  1'b1, 64'hA5, 1'b0, 64'h0,  16'd0};
        tbl[1] = '{1'b0, 1'b0, 7'd0, 1'b0, 7'd0,  64'h11, 1'b0, 1'b0, 7'd5,  1'b0, 64'hA5, 1'b0, 64'h0,  16'd0};
        tbl[2] = '{1'b0, 1'b0, 7'd0, 1'b1, 7'd9,  64'h33, 1'b0, 1'b1, 7'd9,  1'b0, 64'hA5, 1'b1, 64'h33, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 7'd0, 1'b1, 7'd10, 64'h44, 1'b0, 1'b1, 7'd10, 1'b0, 64'hA5, 1'b1, 64'h44, 16'd0};
        tbl[4] = '{1'b1, 1'b1, 7'd3, 1'b0, 7'd0,  64'h55, 1'b1, 1'b0, 7'd3,  1'b1, 64'h55, 1'b0, 64'h44, 16'd0};
        tbl[5] = '{1'b1, 1'b1, 7'd4, 1'b1, 7'd6,  64'h66, 1'b0, 1'b1, 7'd6,  1'b0, 64'h55, 1'b1, 64'h66, 16'd1};
        tbl[6] = '{1'b0, 1'b1, 7'd4, 1'b1, 7'd7,  64'h77, 1'b0, 1'b1, 7'd7,  1'b0, 64'h55, 1'b1, 64'h77, 16'd2};
        tbl[7] = '{1'b0, 1'b1, 7'd4, 1'b1, 7'd7,  64'h88, 1'b1, 1'b0, 7'd4,  1'b1, 64'h88, 1'b0, 64'h77, 16'd3};
        tbl[8] = '{1'b0, 1'b0, 7'd0, 1'b0, 7'd0,  64'h99, 1'b0, 1'b0, 7'd4,  1'b0, 64'h88, 1'b0, 64'h77, 16'd3};

        // reset with both requests high: no grants, everything cleared
        rst = 1'b0; blank = 1'b0;
        vga_req = 1'b1; vga_addr = 7'd33;
        ed_req = 1'b1;  ed_addr = 7'd44;
        mem_rdata = 64'hFFFF;
        #1;
        chk("rst vga_gnt", 64'(vga_gnt), 64'd0);
        chk("rst ed_gnt", 64'(ed_gnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst vga_rvalid", 64'(vga_rvalid), 64'd0);
        chk("rst ed_rvalid", 64'(ed_rvalid), 64'd0);
        chk("rst vga_rdata", vga_rdata, 64'd0);
        chk("rst ed_rdata", ed_rdata, 64'd0);
        chk("rst conflict_cnt", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        vga_req = 1'b0; ed_req = 1'b0; rst = 1'b1;

        // single-request latency, back-to-back, mode lag both ways, withdrawal
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset in the cycle after a grant
        @(negedge clk);
        vga_req = 1'b1; vga_addr = 7'd20; ed_req = 1'b0; mem_rdata = 64'hDEAD; blank = 1'b0;
        @(posedge clk);
        #1;
        chk("prerst vga_rvalid", 64'(vga_rvalid), 64'd1);
        chk("prerst vga_rdata", vga_rdata, 64'hDEAD);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst vga_rvalid", 64'(vga_rvalid), 64'd0);
        chk("midrst ed_rvalid", 64'(ed_rvalid), 64'd0);
        chk("midrst conflict_cnt", 64'(conflict_cnt), 64'd0);
        chk("midrst mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst vga_gnt", 64'(vga_gnt), 64'd0);
        chk("midrst vga_rdata", vga_rdata, 64'd0);
        @(posedge clk);
        #1;
        chk("midrst hold vga_rvalid", 64'(vga_rvalid), 64'd0);
        @(negedge clk);
        vga_req = 1'b0; ed_req = 1'b0; rst = 1'b1;
        exp_vrd = '0; exp_erd = '0; exp_cnt = '0; exp_maddr = '0;

        // VGA-priority contention: ED gets every 9th slot
        for (int i = 1; i <= 18; i++) begin
            run(1'b0, 1'b1, 7'd1, 1'b1, 7'd2, 64'h1000 + 64'(i),
                (i % 9) != 0, (i % 9) == 0, $sformatf("cont%0d", i));
        end
        chk("cont conflict_cnt 18", 64'(conflict_cnt), 64'd18);

        // blank rises: ED wins from the next cycle, VGA forced after 8 denials
        for (int j = 1; j <= 11; j++) begin
            run(1'b1, 1'b1, 7'd1, 1'b1, 7'd2, 64'h2000 + 64'(j),
                (j == 1) || (j == 10), !((j == 1) || (j == 10)), $sformatf("blank%0d", j));
        end
        // blank falls: VGA priority back one cycle later
        for (int k = 1; k <= 3; k++) begin
            run(1'b0, 1'b1, 7'd1, 1'b1, 7'd2, 64'h3000 + 64'(k),
                k != 1, k == 1, $sformatf("unblank%0d", k));
        end

        // ED withdraw restarts its starvation count; address change served at grant
        run(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 64'h4000, 1'b0, 1'b0, "idle");
        for (int i = 1; i <= 5; i++)
            run(1'b0, 1'b1, 7'd8, 1'b1, 7'd2, 64'h4100 + 64'(i), 1'b1, 1'b0, $sformatf("pre%0d", i));
        run(1'b0, 1'b1, 7'd8, 1'b0, 7'd3, 64'h4200, 1'b1, 1'b0, "withdraw");
        for (int i = 1; i <= 9; i++)
            run(1'b0, 1'b1, 7'd8, 1'b1, 7'd3, 64'h4300 + 64'(i), i != 9, i == 9, $sformatf("reassert%0d", i));

        // ED-only address walk with wrap
        for (int i = 0; i <= 128; i++)
            run(1'b0, 1'b0, 7'd0, 1'b1, 7'(i % 128), 64'(i % 128), 1'b0, 1'b1, $sformatf("walk%0d", i));
        run(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 64'h5000, 1'b0, 1'b0, "end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Shares the single 128x64 frame-memory read port between two requesters: the VGA scan-out (reads every active pixel word) and the edge detector (bulk reads to fill RAM).
- Replaces the ad-hoc request-select mux with a cycle-accurate arbiter providing per-requester request/grant/valid handshakes and registered read data.
- Priority follows the display phase: VGA wins during active video, the edge detector wins during blanking. Starvation counters prevent either side from being locked out.

Parameters:
- ADDR_W, 7, frame-memory address width.
- DATA_W, 64, frame-memory word width.
- STARVE_LIMIT, 8, consecutive denied cycles before the low-priority requester is forced a grant (range 1..255).
- CNT_W, 16, width of the conflict statistics counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- blank  in  1  1 = VGA in horizontal or vertical blanking; selects the priority mode.
- vga_req  in  1  VGA read request.
- vga_addr  in  ADDR_W  VGA read address, valid while vga_req=1.
- vga_gnt  out  1  VGA request accepted this cycle (combinational).
- vga_rdata  out  DATA_W  registered read data for VGA.
- vga_rvalid  out  1  vga_rdata valid (one-cycle pulse).
- ed_req  in  1  edge-detector read request.
- ed_addr  in  ADDR_W  edge-detector read address.
- ed_gnt  out  1  edge-detector request accepted this cycle (combinational).
- ed_rdata  out  DATA_W  registered read data for the edge detector.
- ed_rvalid  out  1  ed_rdata valid (one-cycle pulse).
- mem_addr  out  ADDR_W  address to the frame memory (combinational-read).
- mem_rdata  in  DATA_W  frame-memory read data, valid the same cycle as mem_addr.
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests high.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = VGA_PRIO.
  - Both starvation counters = 0; last_addr = 0; conflict_cnt = 0.
  - vga_rdata, ed_rdata = 0; vga_rvalid, ed_rvalid = 0.
  - Both grants are forced to 0 while rst=0.
- FSM, 2 states, registered:
  - VGA_PRIO -> ED_PRIO when blank=1.
  - ED_PRIO -> VGA_PRIO when blank=0.
  - The state updates on the clock edge, so the mode lags blank by one cycle.
- Grant rule (combinational, at most one grant per cycle):
  - Only one request high: that requester is granted.
  - Both high: the mode's high-priority side is granted, unless the low-priority side's starvation counter equals STARVE_LIMIT; then the low-priority side is granted.
  - Neither high: no grant.
- mem_addr:
  - Equals the granted requester's address.
  - With no grant it holds last_addr, which is updated to the granted address on every granted cycle.
- Read latency = 1 cycle:
  - On the edge following a grant, the granted side's rdata <= mem_rdata and its rvalid = 1 for exactly one cycle.
  - The other side's rdata holds its previous value and its rvalid = 0.
  - Back-to-back grants to the same side give consecutive rvalid pulses.
- Starvation counters, one per side:
  - Increment when that side's req=1 and gnt=0.
  - Clear when that side is granted or its req=0.
  - Saturate at STARVE_LIMIT.
  - A forced grant clears the counter, so the low-priority side gets one slot per STARVE_LIMIT+1 contended cycles.
- Handshake:
  - Requester holds req and addr stable until gnt.
  - Dropping req before gnt (withdraw) is legal and clears that side's counter.
  - Address changes while req=1 without gnt are legal; the address sampled on the grant cycle is served.
- conflict_cnt increments each cycle with vga_req=1 and ed_req=1, saturating at all-ones.
- A blank change while both sides are requesting takes effect at the next cycle's arbitration; a grant issued in the current cycle completes normally.
- Reset mid-operation: a pending rvalid is discarded (it stays 0) and no response is issued for requests granted in the reset cycle.

Test Plan:
- Reset, then vga_req=1, vga_addr=5, mem_rdata=0xA5 (blank=0) -> vga_gnt=1 same cycle, mem_addr=5; next cycle vga_rvalid=1, vga_rdata=0xA5; ed_rvalid=0.
- blank=0, both requesting continuously (vga_addr=1, ed_addr=2) -> VGA granted 8 cycles, ED granted on cycle 9 (mem_addr=2), pattern repeats with period 9; conflict_cnt=18 after 18 cycles.
- blank rises while both requesting -> cycle after the rise ED is granted; VGA is force-granted once after 8 denials; blank falls -> VGA priority restored one cycle later.
- ed_req high 5 cycles under VGA contention, then drops 1 cycle, then re-asserts -> starvation counter restarts at 0, so the forced grant comes 8 contended cycles after re-assertion.
- Only ed_req=1, ed_addr walks 0..127 with mem_rdata = address -> ed_gnt=1 every cycle, ed_rdata equals the previous cycle's address, 128 consecutive rvalid pulses, mem_addr wraps 127->0.
- Assert rst=0 asynchronously in the cycle after a grant -> vga_rvalid/ed_rvalid drop to 0 immediately, conflict_cnt=0, mem_addr=0; after release, arbitration resumes in VGA_PRIO.
